// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for alu_sequencer: FSM state encoding, ALU opcode names
// and the opcode-class helpers used to steer completion pulses.
package alu_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_MULT = 4'd4,
        OP_XOR  = 4'd5,
        OP_NOR  = 4'd6,
        OP_RST  = 4'd7,
        OP_BE   = 4'd8,
        OP_BNE  = 4'd9,
        OP_BLT  = 4'd10,
        OP_BGT  = 4'd11,
        OP_BLE  = 4'd12,
        OP_BGE  = 4'd13,
        OP_SLT  = 4'd14,
        OP_LILO = 4'd15
    } op_e;

    function automatic logic is_branch(input int unsigned op);
        return (op >= int'(OP_BE)) && (op <= int'(OP_BGE));
    endfunction

    function automatic logic is_wb(input int unsigned op);
        return (op <= int'(OP_RST)) || (op == int'(OP_SLT)) || (op == int'(OP_LILO));
    endfunction

    // Only ADD and MULT report a meaningful upper word; the ALU leaves it undefined otherwise.
    function automatic logic has_upper_word(input int unsigned op);
        return (op == int'(OP_ADD)) || (op == int'(OP_MULT));
    endfunction

endpackage

// File: rtl/alu_seq_target.sv
// Combinational branch-target adder: pc + 4 + (word offset << 2), wrapping modulo 2^n.
module alu_seq_target #(
    parameter int n = 32
) (
    input  logic [n-1:0] i_pc,
    input  logic [n-1:0] i_offset,
    output logic [n-1:0] o_target
);

    localparam logic [n-1:0] c_four = n'(4);

    assign o_target = i_pc + c_four + (i_offset << 2);

endmodule

// File: rtl/alu_sequencer.sv
// Issue/complete controller in front of the registered ALU: accept, issue, wait for the
// ALU result edge, then emit a writeback, branch or error pulse. Optional macro ALU_SEQ_HILO_EN adds the hi register.
`ifndef WORDSIZE
`define WORDSIZE 32
`endif
`ifndef CW
`define CW 4
`endif

module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int n   = `WORDSIZE,
    parameter int c_w = `CW,
    parameter int r_w = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [c_w-1:0] req_aluop,
    input  logic [n-1:0]   req_a,
    input  logic [n-1:0]   req_b,
    input  logic [r_w-1:0] req_rd,
    input  logic [n-1:0]   req_pc,
    input  logic [n-1:0]   req_offset,
    output logic [n-1:0]   alu_src1,
    output logic [n-1:0]   alu_src2,
    output logic [c_w-1:0] alu_op,
    input  logic [n-1:0]   alu_dest,
    input  logic           alu_zero,
    input  logic [n-1:0]   alu_overflow,
    output logic           wb_valid,
    output logic [r_w-1:0] wb_rd,
    output logic [n-1:0]   wb_data,
    output logic           br_valid,
    output logic           br_taken,
    output logic [n-1:0]   br_target,
    output logic           ovf_flag,
    output logic           err,
`ifdef ALU_SEQ_HILO_EN
    output logic [n-1:0]   hi,
`endif
    output logic           busy
);

    state_e         r_state;
    state_e         w_state_next;
    logic           w_accept;
    logic [r_w-1:0] r_rd;
    logic [n-1:0]   w_target;
    int unsigned    w_op_idx;
    logic           w_is_wb;
    logic           w_is_br;
    logic           w_upper_op;

    assign req_ready  = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign w_accept   = req_valid && req_ready;
    // alu_op holds the latched opcode for the whole operation, so it doubles as the class selector.
    assign w_op_idx   = 32'(alu_op);
    assign w_is_wb    = is_wb(w_op_idx);
    assign w_is_br    = is_branch(w_op_idx);
    assign w_upper_op = has_upper_word(w_op_idx);

    alu_seq_target #(.n(n)) u_target (
        .i_pc     (req_pc),
        .i_offset (req_offset),
        .o_target (w_target)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_next = ST_ISSUE;
            ST_ISSUE: w_state_next = ST_WAIT;
            ST_WAIT:  w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_src1  <= '0;
            alu_src2  <= '0;
            alu_op    <= c_w'(OP_RST);
            r_rd      <= '0;
            br_target <= '0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            br_valid  <= 1'b0;
            br_taken  <= 1'b0;
            ovf_flag  <= 1'b0;
            err       <= 1'b0;
`ifdef ALU_SEQ_HILO_EN
            hi        <= '0;
`endif
        end else begin
            wb_valid <= 1'b0;
            br_valid <= 1'b0;
            ovf_flag <= 1'b0;
            err      <= 1'b0;
            if (w_accept) begin
                alu_src1  <= req_a;
                alu_src2  <= req_b;
                alu_op    <= req_aluop;
                r_rd      <= req_rd;
                br_target <= w_target;
            end
            // The edge leaving WAIT is the first one at which the ALU result is valid.
            if (r_state == ST_WAIT) begin
                wb_valid <= w_is_wb && (r_rd != '0);
                br_valid <= w_is_br;
                err      <= !w_is_wb && !w_is_br;
                ovf_flag <= w_upper_op ? (|alu_overflow) : 1'b0;
                if (w_is_wb) begin
                    wb_data <= alu_dest;
                    wb_rd   <= r_rd;
                end
                if (w_is_br) begin
                    br_taken <= alu_zero;
                end
`ifdef ALU_SEQ_HILO_EN
                if (w_op_idx == int'(OP_MULT)) begin
                    hi <= alu_overflow;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a registered ALU model and a completion scoreboard;
// a second instance with a 5-bit opcode covers the illegal-opcode path.
module tb_alu_sequencer;

    localparam int N  = 32;
    localparam int RW = 5;
    localparam int K_WB   = 0;
    localparam int K_BR   = 1;
    localparam int K_NONE = 2;

    typedef struct {
        int          kind;
        logic [N-1:0]  data;
        logic [RW-1:0] rd;
        logic          ovf;
        logic          taken;
        logic [N-1:0]  target;
        logic [N-1:0]  hi;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          req_valid, req_ready;
    logic [3:0]    req_aluop;
    logic [N-1:0]  req_a, req_b, req_pc, req_offset;
    logic [RW-1:0] req_rd;
    logic [N-1:0]  alu_src1, alu_src2, alu_dest, alu_overflow;
    logic [3:0]    alu_op;
    logic          alu_zero;
    logic          wb_valid, br_valid, br_taken, ovf_flag, err, busy;
    logic [RW-1:0] wb_rd;
    logic [N-1:0]  wb_data, br_target;
    logic [N-1:0]  hi;

    logic          req_valid5, req_ready5;
    logic [4:0]    req_aluop5, alu_op5;
    logic [N-1:0]  alu_src1_5, alu_src2_5, wb_data5, br_target5;
    logic          wb_valid5, br_valid5, br_taken5, ovf_flag5, err5, busy5;
    logic [RW-1:0] wb_rd5;
    logic [N-1:0]  hi5;
    logic [N-1:0]  alu_dest5 = 32'h0000_1234;
    logic [N-1:0]  alu_overflow5 = '1;
    logic          alu_zero5 = 1'b1;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    alu_sequencer #(.n(N), .c_w(4), .r_w(RW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_aluop(req_aluop),
        .req_a(req_a), .req_b(req_b), .req_rd(req_rd), .req_pc(req_pc), .req_offset(req_offset),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_op(alu_op),
        .alu_dest(alu_dest), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
        .ovf_flag(ovf_flag), .err(err),
`ifdef ALU_SEQ_HILO_EN
        .hi(hi),
`endif
        .busy(busy)
    );

    alu_sequencer #(.n(N), .c_w(5), .r_w(RW)) dut5 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid5), .req_ready(req_ready5), .req_aluop(req_aluop5),
        .req_a(req_a), .req_b(req_b), .req_rd(req_rd), .req_pc(req_pc), .req_offset(req_offset),
        .alu_src1(alu_src1_5), .alu_src2(alu_src2_5), .alu_op(alu_op5),
        .alu_dest(alu_dest5), .alu_zero(alu_zero5), .alu_overflow(alu_overflow5),
        .wb_valid(wb_valid5), .wb_rd(wb_rd5), .wb_data(wb_data5),
        .br_valid(br_valid5), .br_taken(br_taken5), .br_target(br_target5),
        .ovf_flag(ovf_flag5), .err(err5),
`ifdef ALU_SEQ_HILO_EN
        .hi(hi5),
`endif
        .busy(busy5)
    );

`ifndef ALU_SEQ_HILO_EN
    assign hi  = '0;
    assign hi5 = '0;
`endif

    // Registered ALU model; the upper word is all-ones for ops where the real ALU leaves it undefined.
    logic [63:0]  m_sum, m_prod;
    logic [N-1:0] m_dest, m_ovf;
    logic         m_zero;
    always_comb begin
        m_sum  = 64'(alu_src1) + 64'(alu_src2);
        m_prod = 64'(alu_src1) * 64'(alu_src2);
        m_dest = '0;
        m_ovf  = '1;
        m_zero = 1'b0;
        case (alu_op)
            4'd0: begin m_dest = m_sum[31:0];  m_ovf = m_sum[63:32];  end
            4'd3: m_dest = alu_src1 | alu_src2;
            4'd4: begin m_dest = m_prod[31:0]; m_ovf = m_prod[63:32]; end
            4'd8: m_zero = (alu_src1 == alu_src2);
            4'd9: m_zero = (alu_src1 != alu_src2);
            default: m_dest = '0;
        endcase
    end
    always_ff @(posedge clk) begin
        alu_dest     <= m_dest;
        alu_overflow <= m_ovf;
        alu_zero     <= m_zero;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input int kind, input logic [N-1:0] data, input logic [RW-1:0] rd,
                                input logic ovf, input logic taken, input logic [N-1:0] target,
                                input logic [N-1:0] hiv);
        exp_t e;
        e.kind = kind; e.data = data; e.rd = rd; e.ovf = ovf;
        e.taken = taken; e.target = target; e.hi = hiv;
        return e;
    endfunction

    task automatic run_op(input string name, input logic [3:0] op, input logic [N-1:0] a,
                          input logic [N-1:0] b, input logic [RW-1:0] rd, input logic [N-1:0] pc,
                          input logic [N-1:0] off, input exp_t e);
        exp_t got;
        sb.push_back(e);
        @(negedge clk);
        chk({name, "_ready_pre"}, req_ready, 1);
        req_valid = 1'b1; req_aluop = op; req_a = a; req_b = b;
        req_rd = rd; req_pc = pc; req_offset = off;
        @(negedge clk);
        req_valid = 1'b0;
        chk({name, "_busy_issue"}, busy, 1);
        chk({name, "_ready_issue"}, req_ready, 0);
        chk({name, "_aluop_issue"}, alu_op, op);
        chk({name, "_src1"}, alu_src1, a);
        chk({name, "_src2"}, alu_src2, b);
        chk({name, "_pulses_issue"}, {wb_valid, br_valid, err, ovf_flag}, 0);
        @(negedge clk);
        chk({name, "_pulses_wait"}, {wb_valid, br_valid, err, ovf_flag}, 0);
        @(negedge clk);
        if (sb.size() == 0) begin
            chk({name, "_sb_empty"}, 1, 0);
        end else begin
            got = sb.pop_front();
            chk({name, "_wb_valid"}, wb_valid, got.kind == K_WB);
            if (got.kind == K_WB) begin
                chk({name, "_wb_data"}, wb_data, got.data);
                chk({name, "_wb_rd"}, wb_rd, got.rd);
            end
            chk({name, "_ovf_flag"}, ovf_flag, got.ovf);
            chk({name, "_br_valid"}, br_valid, got.kind == K_BR);
            if (got.kind == K_BR) begin
                chk({name, "_br_taken"}, br_taken, got.taken);
                chk({name, "_br_target"}, br_target, got.target);
            end
            chk({name, "_err"}, err, 0);
`ifdef ALU_SEQ_HILO_EN
            chk({name, "_hi"}, hi, got.hi);
`endif
        end
        @(negedge clk);
        chk({name, "_ready_post"}, req_ready, 1);
        chk({name, "_pulses_post"}, {wb_valid, br_valid, err, ovf_flag}, 0);
        chk({name, "_aluop_hold"}, alu_op, op);
        $display("op %s: a=0x%0h b=0x%0h rd=%0d -> wb_valid=%0b wb_data=0x%0h br_taken=%0b ovf=%0b",
                 name, a, b, rd, wb_valid, wb_data, br_taken, ovf_flag);
    endtask

    initial begin
        int acc[$];
        int wbs;
        int gap1, gap2;

        rst = 1'b1;
        req_valid = 1'b0; req_valid5 = 1'b0;
        req_aluop = '0; req_aluop5 = '0;
        req_a = '0; req_b = '0; req_rd = '0; req_pc = '0; req_offset = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_aluop", alu_op, 7);
        chk("rst_src", {alu_src1, alu_src2}, 0);
        chk("rst_outs", {wb_rd, wb_data, br_target, br_taken}, 0);
        chk("rst_pulses", {wb_valid, br_valid, err, ovf_flag}, 0);
        chk("rst_hi", hi, 0);
        chk("rst_aluop5", alu_op5, 7);

        run_op("add", 4'd0, 32'd5, 32'd7, 5'd3, 32'h0, 32'h0, mk(K_WB, 32'd12, 5'd3, 1'b0, 1'b0, 32'h0, 32'h0));
        run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 5'd4, 32'h0, 32'h0, mk(K_WB, 32'd0, 5'd4, 1'b1, 1'b0, 32'h0, 32'h0));
        run_op("mult", 4'd4, 32'h0001_0000, 32'h0001_0000, 5'd6, 32'h0, 32'h0, mk(K_WB, 32'd0, 5'd6, 1'b1, 1'b0, 32'h0, 32'h1));
        run_op("be", 4'd8, 32'd9, 32'd9, 5'd0, 32'h100, 32'hFFFF_FFFE, mk(K_BR, 32'd0, 5'd0, 1'b0, 1'b1, 32'hFC, 32'h1));
        run_op("bne", 4'd9, 32'd9, 32'd9, 5'd0, 32'h200, 32'd3, mk(K_BR, 32'd0, 5'd0, 1'b0, 1'b0, 32'h210, 32'h1));
        run_op("or_rd0", 4'd3, 32'hF0, 32'h0F, 5'd0, 32'h0, 32'h0, mk(K_NONE, 32'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h1));

        // req_valid held high: accepts must land every fourth cycle and never while busy.
        wbs = 0;
        @(negedge clk);
        req_valid = 1'b1; req_aluop = 4'd0; req_a = 32'd1; req_b = 32'd2; req_rd = 5'd5;
        for (int k = 0; k < 12; k++) begin
            if (req_ready) acc.push_back(k);
            chk("ready_while_busy", req_ready && busy, 0);
            if (wb_valid) wbs++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        gap1 = (acc.size() > 1) ? acc[1] - acc[0] : -1;
        gap2 = (acc.size() > 2) ? acc[2] - acc[1] : -1;
        chk("hold_accepts", acc.size(), 3);
        chk("hold_gap1", gap1, 4);
        chk("hold_gap2", gap2, 4);
        chk("hold_wb_count", wbs, 3);
        chk("hold_wb_data", wb_data, 3);
        $display("hold: accepts=%0d gap1=%0d gap2=%0d wb_pulses=%0d", acc.size(), gap1, gap2, wbs);

        // Abort in WAIT with an asynchronous reset between clock edges.
        @(negedge clk);
        req_valid = 1'b1; req_aluop = 4'd0; req_a = 32'd5; req_b = 32'd7; req_rd = 5'd3;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_aluop", alu_op, 7);
        chk("abort_busy", busy, 0);
        chk("abort_ready", req_ready, 1);
        chk("abort_outs", {wb_rd, wb_data, br_target, alu_src1}, 0);
        chk("abort_pulses", {wb_valid, br_valid, err, ovf_flag}, 0);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_no_pulse", {wb_valid, br_valid, err, ovf_flag, busy}, 0);
        end
        $display("abort: reset during WAIT, alu_op=%0d busy=%0b", alu_op, busy);
        run_op("add_after_rst", 4'd0, 32'd5, 32'd7, 5'd3, 32'h0, 32'h0, mk(K_WB, 32'd12, 5'd3, 1'b0, 1'b0, 32'h0, 32'h0));

        // Illegal opcode on the 5-bit-opcode instance.
        @(negedge clk);
        chk("c5_ready_pre", req_ready5, 1);
        req_valid5 = 1'b1; req_aluop5 = 5'd20; req_rd = 5'd7;
        @(negedge clk);
        req_valid5 = 1'b0;
        chk("c5_aluop", alu_op5, 20);
        chk("c5_busy", busy5, 1);
        @(negedge clk);
        chk("c5_err_wait", err5, 0);
        @(negedge clk);
        chk("c5_err_done", err5, 1);
        chk("c5_no_wb_br", {wb_valid5, br_valid5, ovf_flag5}, 0);
        @(negedge clk);
        chk("c5_err_post", err5, 0);
        $display("illegal op 20: err pulse seen, wb_valid=%0b br_valid=%0b", wb_valid5, br_valid5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("c5_rst_ready", req_ready5, 1);
        chk("c5_rst_aluop", alu_op5, 7);
        chk("c5_rst_outs", {alu_src1_5, alu_src2_5, wb_data5, br_target5, wb_rd5, br_taken5, hi5}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle issue/complete controller sitting on the driving side of the registered `alu`. It accepts one decoded operation per valid/ready handshake and drives `aluop` with both operands. Because the ALU registers its result on the next clock edge, the block waits for that edge before capturing `dest`/`zero`/`overflow`. It then emits either a register-writeback pulse or a branch-resolution pulse to the rest of the CPU.

## Interface
Parameters:
- `n`, `` `WORDSIZE `` (32): datapath width.
- `c_w`, `` `CW `` (4): ALU opcode width.
- `r_w`, 5: register-address width.

Ports:
- `clk`  in  1  system clock; all state updates on posedge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req_valid`  in  1  operation request.
- `req_ready`  out  1  block can accept a request.
- `req_aluop`  in  `c_w`  ALU opcode.
- `req_a`, `req_b`  in  `n`  operands.
- `req_rd`  in  `r_w`  destination register.
- `req_pc`  in  `n`  PC of the instruction.
- `req_offset`  in  `n`  signed branch word offset.
- `alu_src1`, `alu_src2`  out  `n`  to ALU `src1`/`src2`.
- `alu_op`  out  `c_w`  to ALU `aluop`.
- `alu_dest`  in  `n`  from ALU `dest`.
- `alu_zero`  in  1  from ALU `zero`.
- `alu_overflow`  in  `n`  from ALU `overflow`.
- `wb_valid`  out  1  one-cycle writeback pulse.
- `wb_rd`  out  `r_w`  writeback register.
- `wb_data`  out  `n`  writeback value.
- `br_valid`  out  1  one-cycle branch-resolved pulse.
- `br_taken`  out  1  branch condition true.
- `br_target`  out  `n`  branch target address.
- `ovf_flag`  out  1  ADD/MULT produced nonzero upper word; valid with `wb_valid`.
- `err`  out  1  one-cycle pulse for an illegal opcode.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE→ISSUE on `req_valid && req_ready`.
  - ISSUE→WAIT unconditionally.
  - WAIT→DONE unconditionally.
  - DONE→IDLE unconditionally.
- `req_ready` = (state == IDLE). No request is accepted in any other state.
- On accept, latch all request fields.
  - `alu_src1`/`alu_src2`/`alu_op` are registered and load the latched values.
  - They hold those values until the next accept.
  - `br_target` = `req_pc + 4 + (req_offset << 2)`, computed at accept, wrap-around modulo 2^n.
- In WAIT, on the posedge leaving WAIT, capture `alu_dest`, `alu_zero` and `alu_overflow`.
- DONE output, by opcode class:
  - Ops 0–7, 14, 15: `wb_valid`=1, `wb_data`=captured `alu_dest`, `wb_rd`=latched rd.
    - If rd==0, `wb_valid` is suppressed; the op still completes.
  - Ops 8–13: `br_valid`=1, `br_taken`=captured `alu_zero`. `wb_valid` stays 0.
  - Ops 0 and 4: `ovf_flag` = OR-reduction of captured `alu_overflow`. For all other ops `ovf_flag`=0; the ALU drives X there, so the block must not propagate it.
  - Opcodes ≥16 (only possible when `c_w` > 4): `err`=1, no wb, no br. The ALU is still driven with that opcode.
- All pulse outputs (`wb_valid`, `br_valid`, `err`, `ovf_flag`) are 0 outside DONE.

## Timing
- Accept edge E0. ALU samples operands at E1. Result is captured at E2. Pulses are high for the single cycle between E2 and E3.
- `req_ready` is high again after E3. Maximum throughput is 1 op per 4 cycles.
- Reset values:
  - State IDLE, `req_ready`=1, `busy`=0.
  - All pulses 0; `wb_rd`, `wb_data`, `br_target`, `br_taken` 0.
  - `alu_src1`/`alu_src2` 0; `alu_op`=7 (RST), so the un-reset ALU clears `dest`.
- Reset asserted mid-operation aborts immediately (asynchronous). No pulse is emitted for the aborted op.
- `req_valid` held high through DONE is accepted only after E3. The request fields must remain stable until accepted.

## Configuration
- `ALU_SEQ_HILO_EN` defined:
  - Adds output `hi` (`n` bits, reset 0).
  - On a MULT (op 4) completion, `hi` loads the captured `alu_overflow`; `hi` holds its value across all other ops.
  - `ovf_flag` behaviour is unchanged.
- `ALU_SEQ_HILO_EN` undefined: port `hi` and its register do not exist. The upper MULT word is observable only through `ovf_flag`.

## Structure
- Shared definitions package holds:
  - The state enum.
  - Named opcode constants 0–15 (ADD … LILO).
  - Class helpers `is_branch(op)` and `is_wb(op)`.
- `WORDSIZE`/`CW` come from the existing definitions file.
- One natural sub-module: `alu_seq_target`, the combinational branch-target adder, instanced at accept.

## Test plan
- ADD 5+7, rd=3 → `wb_valid` pulse 3 cycles after accept edge, `wb_data`=12, `wb_rd`=3, `ovf_flag`=0.
- ADD 0xFFFFFFFF+1 → `wb_data`=0, `ovf_flag`=1. MULT 0x10000×0x10000 → `wb_data`=0, `ovf_flag`=1, and `hi`=1 when the macro is defined.
- BE 9,9 with pc=0x100, offset=−2 → `br_valid`=1, `br_taken`=1, `br_target`=0xFC, `wb_valid`=0.
  - BNE 9,9 → `br_taken`=0.
- OR rd=0 → no `wb_valid`. `req_valid` held high continuously → accepts spaced exactly 4 cycles, never accepted while `busy`.
- `rst` pulsed while in WAIT → outputs at reset values within the same cycle, no pulse emitted, `alu_op`=7. The next request completes normally.
- `c_w`=5 with opcode 20 → `err` pulse in DONE, no wb/br. After reset, `req_ready`=1 and `alu_op`=7.
